// File: rtl/aes_bus_pkg.sv
// Shared definitions for the AES register-bus master: slave address map,
// register bit positions and the transaction state encoding.
package aes_bus_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_CONFIG = 8'h0a;
  localparam logic [7:0] ADDR_KEY    = 8'h10;
  localparam logic [7:0] ADDR_BLOCK  = 8'h20;
  localparam logic [7:0] ADDR_RESULT = 8'h30;

  localparam int CTRL_INIT_BIT     = 0;
  localparam int CTRL_NEXT_BIT     = 1;
  localparam int STATUS_READY_BIT  = 0;
  localparam int STATUS_VALID_BIT  = 1;
  localparam int CONFIG_ENCDEC_BIT = 0;

  // ST_IDLE must stay the all-zero encoding so reset lands there.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_CFG   = 4'd1,
    ST_WR_KEY   = 4'd2,
    ST_WR_INIT  = 4'd3,
    ST_WAIT_RDY = 4'd4,
    ST_WR_BLK   = 4'd5,
    ST_WR_NEXT  = 4'd6,
    ST_WAIT_VLD = 4'd7,
    ST_RD_RES   = 4'd8,
    ST_FIN      = 4'd9
  } state_e;

  // 128-bit register word with a single bit set, used for CTRL/CONFIG writes.
  function automatic logic [127:0] bit_word(input int idx, input logic val);
    logic [127:0] w;
    w = '0;
    w[idx] = val;
    return w;
  endfunction

endpackage

// File: rtl/aes_bus_poller.sv
// Gap counter and STATUS poll decision shared by the ready and valid wait
// phases. Poll timeout counter present only with AES_BUS_MASTER_TIMEOUT_EN.
module aes_bus_poller
  import aes_bus_pkg::*;
#(
  parameter int POLL_GAP = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       active,
  input  logic       wait_valid,
  input  logic [1:0] status,
  output logic       poll_rd,
  output logic       hit,
  output logic       timeout
);

  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP);

  logic [15:0] gap_q, gap_d;
  logic        status_bit;

  // Counters are cleared whenever the phase is not active, so each wait
  // phase starts with a full gap before its first poll.
  assign poll_rd    = active && (gap_q == GAP_LAST);
  assign status_bit = wait_valid ? status[STATUS_VALID_BIT] : status[STATUS_READY_BIT];
  assign hit        = poll_rd && status_bit;

  always_comb begin
    gap_d = gap_q;
    if (!active || poll_rd) begin
      gap_d = '0;
    end else begin
      gap_d = gap_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

`ifdef AES_BUS_MASTER_TIMEOUT_EN
  localparam logic [31:0] POLL_LIMIT = 32'(TIMEOUT);

  logic [31:0] polls_q, polls_d;

  always_comb begin
    polls_d = polls_q;
    if (!active) begin
      polls_d = '0;
    end else if (poll_rd && !status_bit) begin
      polls_d = polls_q + 32'd1;
    end
  end

  // Fires on the failed poll that brings the count up to the limit.
  assign timeout = poll_rd && !status_bit && ((polls_q + 32'd1) >= POLL_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      polls_q <= '0;
    end else begin
      polls_q <= polls_d;
    end
  end
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT;
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/aes_bus_master.sv
// Register-bus initiator running a full AES transaction against the AES
// register slave. Optional poll timeout enabled by AES_BUS_MASTER_TIMEOUT_EN.
module aes_bus_master
  import aes_bus_pkg::*;
#(
  parameter int POLL_GAP = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         encdec,
  input  logic         key_reuse,
  input  logic [127:0] key,
  input  logic [127:0] block,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] result,
  output logic         cs,
  output logic         we,
  output logic [7:0]   address,
  output logic [127:0] write_data,
  input  logic [127:0] read_data
);

`ifdef AES_BUS_MASTER_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  state_e       state_q, state_d;
  logic         key_loaded_q, key_loaded_d;
  logic         err_q, err_d;
  logic         enc_q, enc_d;
  logic [127:0] key_q, key_d;
  logic [127:0] block_q, block_d;
  logic [127:0] result_q, result_d;

  logic poll_active, poll_rd, poll_hit, poll_timeout;

  assign poll_active = (state_q == ST_WAIT_RDY) || (state_q == ST_WAIT_VLD);

  aes_bus_poller #(
    .POLL_GAP (POLL_GAP),
    .TIMEOUT  (TIMEOUT)
  ) u_poller (
    .clk        (clk),
    .rst        (rst),
    .active     (poll_active),
    .wait_valid (state_q == ST_WAIT_VLD),
    .status     (read_data[1:0]),
    .poll_rd    (poll_rd),
    .hit        (poll_hit),
    .timeout    (poll_timeout)
  );

  // Bus outputs are decoded from the state register alone, so an async
  // reset drops cs in the same cycle.
  always_comb begin
    state_d      = state_q;
    key_loaded_d = key_loaded_q;
    err_d        = err_q;
    enc_d        = enc_q;
    key_d        = key_q;
    block_d      = block_q;
    result_d     = result_q;
    cs           = 1'b0;
    we           = 1'b0;
    address      = '0;
    write_data   = '0;
    done         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          enc_d   = encdec;
          key_d   = key;
          block_d = block;
          err_d   = 1'b0;
          state_d = (key_reuse && key_loaded_q) ? ST_WR_BLK : ST_WR_CFG;
        end
      end
      ST_WR_CFG: begin
        cs         = 1'b1;
        we         = 1'b1;
        address    = ADDR_CONFIG;
        write_data = bit_word(CONFIG_ENCDEC_BIT, enc_q);
        state_d    = ST_WR_KEY;
      end
      ST_WR_KEY: begin
        cs         = 1'b1;
        we         = 1'b1;
        address    = ADDR_KEY;
        write_data = key_q;
        state_d    = ST_WR_INIT;
      end
      ST_WR_INIT: begin
        cs           = 1'b1;
        we           = 1'b1;
        address      = ADDR_CTRL;
        write_data   = bit_word(CTRL_INIT_BIT, 1'b1);
        key_loaded_d = 1'b1;
        state_d      = ST_WAIT_RDY;
      end
      ST_WAIT_RDY, ST_WAIT_VLD: begin
        if (poll_rd) begin
          cs      = 1'b1;
          address = ADDR_STATUS;
        end
        if (poll_hit) begin
          state_d = (state_q == ST_WAIT_RDY) ? ST_WR_BLK : ST_RD_RES;
        end else if (poll_timeout) begin
          // The slave may be wedged; force a full key load next time.
          err_d        = 1'b1;
          key_loaded_d = 1'b0;
          state_d      = ST_FIN;
        end
      end
      ST_WR_BLK: begin
        cs         = 1'b1;
        we         = 1'b1;
        address    = ADDR_BLOCK;
        write_data = block_q;
        state_d    = ST_WR_NEXT;
      end
      ST_WR_NEXT: begin
        cs         = 1'b1;
        we         = 1'b1;
        address    = ADDR_CTRL;
        write_data = bit_word(CTRL_NEXT_BIT, 1'b1);
        state_d    = ST_WAIT_VLD;
      end
      ST_RD_RES: begin
        cs       = 1'b1;
        address  = ADDR_RESULT;
        result_d = read_data;
        state_d  = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign err    = TIMEOUT_EN && (state_q == ST_FIN) && err_q;
  assign result = result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      key_loaded_q <= 1'b0;
      err_q        <= 1'b0;
      enc_q        <= 1'b0;
      key_q        <= '0;
      block_q      <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      key_loaded_q <= key_loaded_d;
      err_q        <= err_d;
      enc_q        <= enc_d;
      key_q        <= key_d;
      block_q      <= block_d;
      result_q     <= result_d;
    end
  end

endmodule

// File: tb/tb_aes_bus_master.sv
// Self-checking bench for aes_bus_master: stand-in AES register slave,
// transaction-level model of bus traffic, latency and result.
module tb_aes_bus_master;

  localparam int G   = 2;
  localparam int TMO = 4;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst, start, encdec, key_reuse;
  logic [127:0] key, block, result, write_data, read_data;
  logic busy, done, err, cs, we;
  logic [7:0] address;

  always #5 clk = ~clk;

  aes_bus_master #(.POLL_GAP(G), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .encdec(encdec), .key_reuse(key_reuse),
    .key(key), .block(block), .busy(busy), .done(done), .err(err), .result(result),
    .cs(cs), .we(we), .address(address), .write_data(write_data), .read_data(read_data)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input bit ok, input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stand-in cipher: real FIPS-197 answers for the known vectors, otherwise a
  // key/block/mode dependent scramble so wrong bus writes show up in result.
  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] b, input logic e);
    if (e && k == FIPS_KEY && b == FIPS_PT) return FIPS_CT;
    if (!e && k == FIPS_KEY && b == FIPS_CT) return FIPS_PT;
    if (e) return {b[119:0], b[127:120]} ^ k;
    return {b[7:0], b[127:8]} ^ ~k;
  endfunction

  // ---------------- slave ----------------
  int cfg_rf = 0, cfg_vf = 0;
  logic sl_enc = 1'b0;
  logic [127:0] sl_key = '0, sl_blk = '0, sl_res = '0;
  int sl_phase = 0, sl_rf = 0, sl_vf = 0;

  always @(posedge clk) begin
    if (cs && we) begin
      case (address)
        8'h0a: sl_enc <= write_data[0];
        8'h10: sl_key <= write_data;
        8'h20: sl_blk <= write_data;
        8'h08: begin
          if (write_data[0]) begin sl_phase <= 1; sl_rf <= cfg_rf; end
          if (write_data[1]) begin sl_phase <= 2; sl_vf <= cfg_vf; sl_res <= cipher(sl_key, sl_blk, sl_enc); end
        end
        default: ;
      endcase
    end else if (cs && address == 8'h09) begin
      if (sl_phase == 1 && sl_rf > 0) sl_rf <= sl_rf - 1;
      if (sl_phase == 2 && sl_vf > 0) sl_vf <= sl_vf - 1;
    end
  end

  always_comb begin
    read_data = '0;
    if (cs && !we) begin
      if (address == 8'h09)
        read_data = {126'd0, (sl_phase == 2 && sl_vf == 0), !(sl_phase == 1 && sl_rf > 0)};
      else if (address == 8'h30)
        read_data = sl_res;
    end
  end

  // ---------------- model ----------------
  typedef struct packed { logic we; logic [7:0] addr; logic [127:0] wd; } op_t;
  op_t exp_q[$];
  int edge_cnt = 0;
  int s_edge = 0, lat = 0;
  bit txn_active = 0, exp_err = 0;
  logic [127:0] exp_res = '0, pend_res = '0, m_key = '0;
  logic m_enc = 1'b0;
  bit m_key_loaded = 0;
  int last_done_edge = -1, last_err_edge = -1, key_wr_cnt = 0;

  function automatic op_t mk(input logic w, input logic [7:0] a, input logic [127:0] d);
    op_t o;
    o.we = w; o.addr = a; o.wd = d;
    return o;
  endfunction

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Single compare process: every cycle, outputs against the model.
  always @(negedge clk) begin : monitor
    bit exp_busy, exp_done;
    op_t e;
    if (rst) begin
      chk({cs, we, busy, done, err} == 5'b0, "rst_ctl", 160'({cs, we, busy, done, err}), 160'd0);
      chk(address == 8'd0 && write_data == '0, "rst_bus", 160'({address, write_data}), 160'd0);
      chk(result == '0, "rst_result", 160'(result), 160'd0);
    end else begin
      exp_busy = txn_active && edge_cnt >= s_edge && edge_cnt < s_edge + lat;
      exp_done = txn_active && edge_cnt == s_edge + lat - 1;
      if (exp_done && !exp_err) exp_res = pend_res;
      if (done) last_done_edge = edge_cnt;
      if (err) last_err_edge = edge_cnt;
      chk(busy == exp_busy, "busy", 160'(busy), 160'(exp_busy));
      chk(done == exp_done, "done", 160'(done), 160'(exp_done));
      chk(err == (exp_done && exp_err), "err", 160'(err), 160'(exp_done && exp_err));
      chk(result == exp_res, "result", 160'(result), 160'(exp_res));
      if (cs) begin
        if (we && address == 8'h10) key_wr_cnt++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "bus_extra", 160'({we, address, write_data}), 160'd0);
        end else begin
          e = exp_q.pop_front();
          chk({we, address, write_data} == e, "bus_op", 160'({we, address, write_data}), 160'(e));
        end
      end else begin
        chk(!we && address == 8'd0 && write_data == '0, "bus_idle", 160'({we, address, write_data}), 160'd0);
      end
      if (exp_done) begin
        chk(exp_q.size() == 0, "bus_missing", 160'(exp_q.size()), 160'd0);
        txn_active = 0;
      end
    end
  end

  // One transaction: build expected traffic/latency, drive start, wait for
  // done (or abort with reset at abort_at edges after the start edge).
  task automatic run_txn(input logic enc, input logic reuse, input logic [127:0] k, input logic [127:0] b,
                         input int rf, input int vf, input bit glitch, input int abort_at);
    bit full, to;
    cfg_rf = rf;
    cfg_vf = vf;
    full = !(reuse && m_key_loaded);
    to = 0;
`ifdef AES_BUS_MASTER_TIMEOUT_EN
    to = full && (rf >= TMO);
`endif
    exp_q.delete();
    if (full) begin
      m_enc = enc;
      m_key = k;
      exp_q.push_back(mk(1'b1, 8'h0a, 128'(enc)));
      exp_q.push_back(mk(1'b1, 8'h10, k));
      exp_q.push_back(mk(1'b1, 8'h08, 128'd1));
      repeat (to ? TMO : rf + 1) exp_q.push_back(mk(1'b0, 8'h09, '0));
    end
    if (!to) begin
      exp_q.push_back(mk(1'b1, 8'h20, b));
      exp_q.push_back(mk(1'b1, 8'h08, 128'd2));
      repeat (vf + 1) exp_q.push_back(mk(1'b0, 8'h09, '0));
      exp_q.push_back(mk(1'b0, 8'h30, '0));
    end
    if (to) lat = 4 + TMO * (G + 1);
    else if (full) lat = 7 + (G + 1) * (rf + vf + 2);
    else lat = 4 + (G + 1) * (vf + 1);
    pend_res = cipher(m_key, b, m_enc);
    exp_err = to;
    if (full) m_key_loaded = !to;

    @(posedge clk); #1;
    encdec = enc; key_reuse = reuse; key = k; block = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_edge = edge_cnt;
    txn_active = 1;

    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      #1;
      chk(cs && !we && address == 8'h09, "pre_abort_poll", 160'({cs, we, address}), 160'({1'b1, 1'b0, 8'h09}));
      rst = 1'b1;
      #1;
      chk(!cs && !busy && !done, "abort_ctl", 160'({cs, busy, done}), 160'd0);
      chk(result == '0, "abort_result", 160'(result), 160'd0);
      txn_active = 0;
      exp_q.delete();
      exp_res = '0;
      m_key_loaded = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      return;
    end

    if (glitch) begin
      repeat ($urandom_range(lat - 3, 0)) @(posedge clk);
      #1;
      start = 1'b1; key = ~k; block = ~b; encdec = ~enc; key_reuse = ~reuse;
      @(posedge clk); #1;
      start = 1'b0;
    end

    for (int i = 0; i < 4000 && txn_active; i++) @(posedge clk);
    if (txn_active) begin
      chk(1'b0, "txn_timeout", 160'(edge_cnt), 160'(s_edge + lat));
      txn_active = 0;
    end
  endtask

  initial begin
    int kw;
    rst = 1'b1; start = 1'b0; encdec = 1'b0; key_reuse = 1'b0; key = '0; block = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // FIPS-197 encrypt, full path: done at N+13.
    run_txn(1'b1, 1'b0, FIPS_KEY, FIPS_PT, 0, 0, 1'b0, 0);
    chk(last_done_edge - s_edge == 12, "fips_enc_lat", 160'(last_done_edge - s_edge), 160'd12);
    chk(result == FIPS_CT, "fips_enc_res", 160'(result), 160'(FIPS_CT));

    // Key reuse: no CONFIG/KEY/INIT, done at N+7.
    kw = key_wr_cnt;
    run_txn(1'b1, 1'b1, FIPS_KEY, FIPS_PT, 0, 0, 1'b0, 0);
    chk(last_done_edge - s_edge == 6, "reuse_lat", 160'(last_done_edge - s_edge), 160'd6);
    chk(key_wr_cnt == kw, "reuse_no_key", 160'(key_wr_cnt), 160'(kw));
    chk(result == FIPS_CT, "reuse_res", 160'(result), 160'(FIPS_CT));

    // Decrypt.
    run_txn(1'b0, 1'b0, FIPS_KEY, FIPS_CT, 0, 0, 1'b0, 0);
    chk(result == FIPS_PT, "fips_dec_res", 160'(result), 160'(FIPS_PT));

    // Valid held low for three polls: +9 cycles on the reuse path.
    run_txn(1'b0, 1'b1, FIPS_KEY, FIPS_CT, 0, 3, 1'b0, 0);
    chk(last_done_edge - s_edge == 15, "vld_delay_lat", 160'(last_done_edge - s_edge), 160'd15);
    chk(result == FIPS_PT, "vld_delay_res", 160'(result), 160'(FIPS_PT));

`ifdef AES_BUS_MASTER_TIMEOUT_EN
    // Ready never set: err with done after TMO polls, result kept.
    run_txn(1'b1, 1'b0, FIPS_KEY, FIPS_PT, 1000, 0, 1'b0, 0);
    chk(last_err_edge - s_edge == 15, "timeout_lat", 160'(last_err_edge - s_edge), 160'd15);
    chk(result == FIPS_PT, "timeout_res_kept", 160'(result), 160'(FIPS_PT));
    kw = key_wr_cnt;
    run_txn(1'b1, 1'b1, FIPS_KEY, FIPS_PT, 0, 0, 1'b0, 0);
    chk(key_wr_cnt == kw + 1, "post_timeout_key", 160'(key_wr_cnt), 160'(kw + 1));
    chk(result == FIPS_CT, "post_timeout_res", 160'(result), 160'(FIPS_CT));
`endif

    // Randomised transactions, including ignored starts while busy.
    for (int t = 0; t < 24; t++) begin
      run_txn(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
              int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 0);
      repeat ($urandom_range(3, 0)) @(posedge clk);
    end

    // Reset while polling for valid, then key_reuse must still run full path.
    run_txn(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, FIPS_PT, 0, 50, 1'b0, 10);
    kw = key_wr_cnt;
    run_txn(1'b1, 1'b1, FIPS_KEY, FIPS_PT, 0, 0, 1'b0, 0);
    chk(last_done_edge - s_edge == 12, "post_rst_lat", 160'(last_done_edge - s_edge), 160'd12);
    chk(key_wr_cnt == kw + 1, "post_rst_key", 160'(key_wr_cnt), 160'(kw + 1));
    chk(result == FIPS_CT, "post_rst_res", 160'(result), 160'(FIPS_CT));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
